// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with big-endian line refill.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_wt #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SETS          = 16,
    parameter int unsigned LINE_WORDS    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     re,
    input  logic                     we,
    input  logic                     ByteOp,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    output logic [DATA_WIDTH-1:0]    ReadData,
    output logic                     Stall,
    output logic                     mem_we,
    output logic                     mem_ByteOp,
    output logic [ADDRESS_WIDTH-1:0] mem_Address,
    output logic [DATA_WIDTH-1:0]    mem_WriteData,
    input  logic [DATA_WIDTH-1:0]    mem_ReadData
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OW    = $clog2(BYTES);
    localparam int unsigned WW    = $clog2(LINE_WORDS);
    localparam int unsigned IW    = $clog2(SETS);
    localparam int unsigned TW    = ADDRESS_WIDTH - OW - WW - IW;
    localparam int unsigned SW    = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE, REFILL} state_e;

    state_e                  state_q, state_d;
    logic [WW-1:0]           cnt_q, cnt_d;
    logic [SETS-1:0]         valid_q, valid_d;
    logic [TW-1:0]           tag_q  [SETS];
    logic [DATA_WIDTH-1:0]   data_q [SETS][LINE_WORDS];

    logic                    data_we;
    logic [WW-1:0]           data_word;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    tag_we;

    logic [OW-1:0]           off;
    logic [WW-1:0]           word;
    logic [IW-1:0]           index;
    logic [TW-1:0]           tag;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   sel_word;
    logic [SW-1:0]           lane_sh;
    logic [7:0]              sel_byte;
    logic [DATA_WIDTH-1:0]   merged_word;

    assign off   = Address[OW-1:0];
    assign word  = Address[OW +: WW];
    assign index = Address[OW+WW +: IW];
    assign tag   = Address[ADDRESS_WIDTH-1 -: TW];

    // Byte lane 0 lives in the most significant byte of the word.
    assign hit         = valid_q[index] && (tag_q[index] == tag);
    assign sel_word    = data_q[index][word];
    assign lane_sh     = SW'((BYTES - 1 - 32'(off)) * 8);
    assign sel_byte    = 8'(sel_word >> lane_sh);
    assign merged_word = (sel_word & ~(DATA_WIDTH'(8'hFF) << lane_sh))
                       | (DATA_WIDTH'(WriteData[7:0]) << lane_sh);

    // State register, refill counter and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (tag_we) tag_q[index] <= tag;
        if (data_we) data_q[index][data_word] <= data_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (re && !we && !hit) state_d = REFILL;
            REFILL: if (cnt_q == WW'(LINE_WORDS - 1)) state_d = IDLE;
        endcase
    end

    // Outputs and array updates; the miss cycle in IDLE already fetches word 0.
    always_comb begin
        ReadData      = '0;
        Stall         = 1'b0;
        mem_we        = 1'b0;
        mem_ByteOp    = 1'b0;
        mem_Address   = '0;
        mem_WriteData = '0;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        data_we       = 1'b0;
        data_word     = word;
        data_d        = mem_ReadData;
        tag_we        = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (we) begin
                        mem_we        = 1'b1;
                        mem_ByteOp    = ByteOp;
                        mem_Address   = Address;
                        mem_WriteData = WriteData;
                        if (hit) begin
                            data_we = 1'b1;
                            data_d  = ByteOp ? merged_word : WriteData;
                        end
                    end else if (re) begin
                        if (hit) begin
                            ReadData = ByteOp ? DATA_WIDTH'(sel_byte) : sel_word;
                        end else begin
                            Stall       = 1'b1;
                            mem_Address = {tag, index, {WW{1'b0}}, {OW{1'b0}}};
                            data_we     = 1'b1;
                            data_word   = '0;
                            cnt_d       = WW'(1);
                        end
                    end
                end
                REFILL: begin
                    Stall       = 1'b1;
                    mem_Address = {tag, index, cnt_q, {OW{1'b0}}};
                    data_we     = 1'b1;
                    data_word   = cnt_q;
                    cnt_d       = cnt_q + WW'(1);
                    if (cnt_q == WW'(LINE_WORDS - 1)) begin
                        valid_d[index] = 1'b1;
                        tag_we         = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating load hit/miss counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == IDLE && re && !we) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    // Core protocol checks.
    a_no_re_we: assert property (@(posedge clk) disable iff (rst) !(re && we))
        else $error("dcache_wt: re and we asserted together");
    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        Stall |=> $stable({re, we, ByteOp, Address, WriteData}))
        else $error("dcache_wt: request inputs changed while stalled");

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: scoreboard bench for dcache_wt against a small behavioural data memory.
// Stats counters are checked as well when DCACHE_STATS_EN is defined.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we, ByteOp;
    logic [31:0] Address, WriteData, ReadData;
    logic        Stall, mem_we, mem_ByteOp;
    logic [31:0] mem_Address, mem_WriteData, mem_ReadData;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    logic        pl_en;
    logic [31:0] pl_addr, pl_data;
    logic [31:0] mem [1024];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic [31:0] exp_q [$];
    int          stall_q [$];

    always #5 clk = ~clk;

    dcache_wt dut (
        .clk           (clk),
        .rst           (rst),
        .re            (re),
        .we            (we),
        .ByteOp        (ByteOp),
        .Address       (Address),
        .WriteData     (WriteData),
        .ReadData      (ReadData),
        .Stall         (Stall),
        .mem_we        (mem_we),
        .mem_ByteOp    (mem_ByteOp),
        .mem_Address   (mem_Address),
        .mem_WriteData (mem_WriteData),
        .mem_ReadData  (mem_ReadData)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    function automatic logic [9:0] midx(input logic [31:0] a);
        return {a[17:16], a[9:2]};
    endfunction

    // Data memory: combinational read, big-endian byte writes on posedge.
    always_comb mem_ReadData = mem[midx(mem_Address)];

    always_ff @(posedge clk) begin
        if (pl_en) begin
            mem[midx(pl_addr)] <= pl_data;
        end else if (mem_we) begin
            if (mem_ByteOp)
                mem[midx(mem_Address)][8*(3-int'(mem_Address[1:0])) +: 8] <= mem_WriteData[7:0];
            else
                mem[midx(mem_Address)] <= mem_WriteData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue a load, follow the refill addresses, then pop and compare the result.
    task automatic do_load(input logic [31:0] addr, input logic bop,
                           input logic [31:0] exp_data, input int exp_stalls);
        int n;
        logic [31:0] base;
        @(negedge clk);
        re = 1'b1; we = 1'b0; ByteOp = bop; Address = addr;
        exp_q.push_back(exp_data);
        stall_q.push_back(exp_stalls);
        base = {addr[31:4], 4'h0};
        n = 0;
        #1;
        while (Stall && n < 20) begin
            chk("refill_addr", mem_Address, base + 32'(n * 4));
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 32'(n), 32'(stall_q.pop_front()));
        chk("load_data", ReadData, exp_q.pop_front());
        exp_hits++;
        if (exp_stalls > 0) exp_miss++;
        @(negedge clk);
        re = 1'b0; ByteOp = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic bop, input logic [31:0] wdata);
        @(negedge clk);
        we = 1'b1; re = 1'b0; ByteOp = bop; Address = addr; WriteData = wdata;
        #1;
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_stall", 32'(Stall), 32'd0);
        chk("st_mem_addr", mem_Address, addr);
        chk("st_mem_byteop", 32'(mem_ByteOp), 32'(bop));
        chk("st_mem_wdata", mem_WriteData, wdata);
        @(negedge clk);
        we = 1'b0; ByteOp = 1'b0; WriteData = '0;
    endtask

    initial begin
        rst = 1'b1; re = 1'b1; we = 1'b0; ByteOp = 1'b0;
        Address = 32'h0001_0000; WriteData = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #1;
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_Address, 32'd0);
        chk("rst_mem_wdata", mem_WriteData, 32'd0);
        re = 1'b0;

        preload(32'h0001_0000, 32'hDEAD_BEEF);
        preload(32'h0001_0004, 32'd1);
        preload(32'h0001_0008, 32'd2);
        preload(32'h0001_000C, 32'd3);
        preload(32'h0001_0100, 32'h1111_2222);
        preload(32'h0001_0104, 32'h3333_4444);
        preload(32'h0001_00F0, 32'h9988_7766);
        preload(32'h0001_00F4, 32'h0000_000A);
        preload(32'h0001_00F8, 32'h0000_000B);
        preload(32'h0001_00FC, 32'h0000_000C);
        @(negedge clk);
        rst = 1'b0;

        do_load(32'h0001_0000, 1'b0, 32'hDEAD_BEEF, 4);
        do_load(32'h0001_0001, 1'b1, 32'h0000_00AD, 0);
        do_store(32'h0001_0003, 1'b1, 32'h0000_0055);
        do_load(32'h0001_0000, 1'b0, 32'hDEAD_BE55, 0);
        do_store(32'h0002_0000, 1'b0, 32'hCAFE_F00D);
        do_load(32'h0002_0000, 1'b0, 32'hCAFE_F00D, 4);
        do_load(32'h0001_0000, 1'b0, 32'hDEAD_BE55, 4);
        do_load(32'h0001_0100, 1'b0, 32'h1111_2222, 4);
        do_load(32'h0001_0000, 1'b0, 32'hDEAD_BE55, 4);
        do_load(32'h0001_000C, 1'b0, 32'h0000_0003, 0);
        do_load(32'h0001_0000, 1'b1, 32'h0000_00DE, 0);
        do_load(32'h0001_00F0, 1'b0, 32'h9988_7766, 4);
        do_load(32'h0001_00F2, 1'b1, 32'h0000_0077, 0);
        do_load(32'h0001_00FC, 1'b0, 32'h0000_000C, 0);
        do_store(32'h0001_00F4, 1'b0, 32'h1234_5678);
        do_load(32'h0001_00F4, 1'b0, 32'h1234_5678, 0);
`ifdef DCACHE_STATS_EN
        chk("hit_count", hit_count, 32'(exp_hits));
        chk("miss_count", miss_count, 32'(exp_miss));
`endif

        // Reset in the middle of a refill discards the partial line.
        @(negedge clk);
        re = 1'b1; ByteOp = 1'b0; Address = 32'h0001_0100;
        #1;
        chk("mid_miss_stall", 32'(Stall), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(Stall), 32'd0);
        chk("mid_rst_mem_addr", mem_Address, 32'd0);
        re = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef DCACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
`endif
        do_load(32'h0001_0000, 1'b0, 32'hDEAD_BE55, 4);
        do_load(32'h0001_0100, 1'b0, 32'h1111_2222, 4);
`ifdef DCACHE_STATS_EN
        chk("end_hit_count", hit_count, 32'(exp_hits));
        chk("end_miss_count", miss_count, 32'(exp_miss));
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
